// File: rtl/multicycle_control.sv
// Multicycle MIPS main control: a Moore FSM that sequences lw, sw, R-type, beq,
// bgtz, addi and j. It supports a configurable memory latency, a global enable and illegal-opcode flagging.
module multicycle_control #(
    parameter int MEM_LAT = 1,
    parameter bit EN_BGTZ = 1'b1,
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic [5:0]         opcode,
    output logic               MemtoReg,
    output logic               RegDst,
    output logic               IorD,
    output logic [1:0]         PCSrc,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         ALUOp,
    output logic               IRWrite,
    output logic               MemWrite,
    output logic               PCWrite,
    output logic               Branch,
    output logic               RegWrite,
    output logic               illegal_op,
    output logic               instr_done,
    output logic [STATE_W-1:0] state
);

    localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MEM_LAT - 1);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BGTZ  = 6'b000111;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BEQ     = 4'd8,
        S_BGTZ    = 4'd9,
        S_ADDIEX  = 4'd10,
        S_ADDIWB  = 4'd11,
        S_JUMP    = 4'd12
    } state_t;

    state_t           r_state;
    state_t           w_next;
    state_t           w_dec_next;
    logic [CNT_W-1:0] r_wcnt;
    logic             w_mem_state;
    logic             w_last;
    logic             w_advance;
    logic             w_illegal;

    // Only the memory-facing states wait; everything else finishes in one cycle.
    assign w_mem_state = (r_state == S_FETCH) || (r_state == S_MEMRD) || (r_state == S_MEMWR);
    assign w_last      = w_mem_state ? (r_wcnt == LAST_CNT) : 1'b1;
    assign w_advance   = en && w_last;
    assign state       = STATE_W'(r_state);

    // Opcode dispatch used by DECODE; unknown opcodes fall back to FETCH.
    always_comb begin
        w_dec_next = S_FETCH;
        w_illegal  = 1'b0;
        case (opcode)
            OP_LW, OP_SW: w_dec_next = S_MEMADR;
            OP_RTYPE:     w_dec_next = S_EXECUTE;
            OP_BEQ:       w_dec_next = S_BEQ;
            OP_ADDI:      w_dec_next = S_ADDIEX;
            OP_J:         w_dec_next = S_JUMP;
            OP_BGTZ: begin
                if (EN_BGTZ) begin
                    w_dec_next = S_BGTZ;
                end else begin
                    w_illegal = 1'b1;
                end
            end
            default:      w_illegal = 1'b1;
        endcase
    end

    // Next-state selection, taken only when the current state is on its last cycle.
    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_FETCH:   w_next = S_DECODE;
            S_DECODE:  w_next = w_dec_next;
            S_MEMADR: begin
                if (opcode == OP_SW) begin
                    w_next = S_MEMWR;
                end else begin
                    w_next = S_MEMRD;
                end
            end
            S_MEMRD:   w_next = S_MEMWB;
            S_EXECUTE: w_next = S_ALUWB;
            S_ADDIEX:  w_next = S_ADDIWB;
            default:   w_next = S_FETCH;
        endcase
    end

    // State and wait counter; the counter restarts on every state change.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_FETCH;
            r_wcnt  <= {CNT_W{1'b0}};
        end else if (w_advance) begin
            r_state <= w_next;
            r_wcnt  <= {CNT_W{1'b0}};
        end else if (en) begin
            r_wcnt  <= r_wcnt + CNT_W'(1);
        end else begin
            r_state <= r_state;
            r_wcnt  <= r_wcnt;
        end
    end

    // Moore output decode; strobes are qualified by en, mux selects are not.
    always_comb begin
        MemtoReg   = 1'b0;
        RegDst     = 1'b0;
        IorD       = 1'b0;
        PCSrc      = 2'b00;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        ALUOp      = 2'b00;
        IRWrite    = 1'b0;
        MemWrite   = 1'b0;
        PCWrite    = 1'b0;
        Branch     = 1'b0;
        RegWrite   = 1'b0;
        illegal_op = 1'b0;
        instr_done = 1'b0;
        case (r_state)
            S_FETCH: begin
                ALUSrcB = 2'b01;
                IRWrite = w_advance;
                PCWrite = w_advance;
            end
            S_DECODE: begin
                ALUSrcB    = 2'b11;
                illegal_op = en && w_illegal;
            end
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            S_MEMRD: begin
                IorD = 1'b1;
            end
            S_MEMWB: begin
                MemtoReg   = 1'b1;
                RegWrite   = en;
                instr_done = en;
            end
            S_MEMWR: begin
                IorD       = 1'b1;
                MemWrite   = w_advance;
                instr_done = w_advance;
            end
            S_EXECUTE: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b10;
            end
            S_ALUWB: begin
                RegDst     = 1'b1;
                RegWrite   = en;
                instr_done = en;
            end
            S_BEQ, S_BGTZ: begin
                ALUSrcA    = 1'b1;
                ALUOp      = (r_state == S_BGTZ) ? 2'b11 : 2'b01;
                PCSrc      = 2'b01;
                Branch     = en;
                instr_done = en;
            end
            S_ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            S_ADDIWB: begin
                RegWrite   = en;
                instr_done = en;
            end
            S_JUMP: begin
                PCSrc      = 2'b10;
                PCWrite    = en;
                instr_done = en;
            end
            default: begin
                MemtoReg = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: three instances (MEM_LAT 1/3/2, bgtz off on the
// MEM_LAT=3 one) driven from per-cycle stimulus/expectation entries queued by each test.
module tb_multicycle_control;

    typedef struct {
        logic [5:0]  op;
        logic        en;
        logic        rst;
        logic [3:0]  st;
        logic [16:0] vec;
    } exp_t;

    logic        clk;
    logic        rst [3];
    logic        en  [3];
    logic [5:0]  op  [3];
    logic [16:0] vec [3];
    logic [3:0]  st  [3];

    exp_t q[$];
    int   checks;
    int   errors;

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000, BEQ = 6'b000100;
    localparam logic [5:0] BGTZ = 6'b000111, ADDI = 6'b001000, JMP = 6'b000010, BAD = 6'b111111;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    for (genvar g = 0; g < 3; g++) begin : g_dut
        logic       m2r, rdst, iord, srca, irw, mw, pcw, br, rw, ill, done;
        logic [1:0] pcsrc, srcb, aluop;
        logic [3:0] stt;
        multicycle_control #(
            .MEM_LAT((g == 0) ? 1 : ((g == 1) ? 3 : 2)),
            .EN_BGTZ((g == 1) ? 1'b0 : 1'b1),
            .STATE_W(4)
        ) u_dut (
            .clk(clk), .reset(rst[g]), .en(en[g]), .opcode(op[g]),
            .MemtoReg(m2r), .RegDst(rdst), .IorD(iord), .PCSrc(pcsrc),
            .ALUSrcA(srca), .ALUSrcB(srcb), .ALUOp(aluop), .IRWrite(irw),
            .MemWrite(mw), .PCWrite(pcw), .Branch(br), .RegWrite(rw),
            .illegal_op(ill), .instr_done(done), .state(stt)
        );
        assign vec[g] = {m2r, rdst, iord, pcsrc, srca, srcb, aluop, irw, mw, pcw, br, rw, ill, done};
        assign st[g]  = stt;
    end

    function automatic int lat_of(input int i);
        return (i == 0) ? 1 : ((i == 1) ? 3 : 2);
    endfunction

    function automatic logic illegal_opc(input logic [5:0] o, input int i);
        logic r;
        r = !(o == LW || o == SW || o == RT || o == BEQ || o == ADDI || o == JMP ||
              (o == BGTZ && i != 1));
        return r;
    endfunction

    // Expected control vector for a state, from the per-state output table.
    function automatic logic [16:0] exp_vec(input logic [3:0] s, input logic last,
                                            input logic e, input logic ill);
        logic m2r, rdst, iord, srca, irw, mw, pcw, br, rw, il, dn;
        logic [1:0] pcsrc, srcb, aluop;
        {m2r, rdst, iord, srca, irw, mw, pcw, br, rw, il, dn} = 11'd0;
        pcsrc = 2'b00; srcb = 2'b00; aluop = 2'b00;
        case (s)
            4'd0:  begin srcb = 2'b01; irw = last & e; pcw = last & e; end
            4'd1:  begin srcb = 2'b11; il = ill & e; end
            4'd2:  begin srca = 1'b1; srcb = 2'b10; end
            4'd3:  iord = 1'b1;
            4'd4:  begin m2r = 1'b1; rw = e; dn = e; end
            4'd5:  begin iord = 1'b1; mw = last & e; dn = last & e; end
            4'd6:  begin srca = 1'b1; aluop = 2'b10; end
            4'd7:  begin rdst = 1'b1; rw = e; dn = e; end
            4'd8:  begin srca = 1'b1; aluop = 2'b01; pcsrc = 2'b01; br = e; dn = e; end
            4'd9:  begin srca = 1'b1; aluop = 2'b11; pcsrc = 2'b01; br = e; dn = e; end
            4'd10: begin srca = 1'b1; srcb = 2'b10; end
            4'd11: begin rw = e; dn = e; end
            4'd12: begin pcsrc = 2'b10; pcw = e; dn = e; end
            default: dn = 1'b0;
        endcase
        return {m2r, rdst, iord, pcsrc, srca, srcb, aluop, irw, mw, pcw, br, rw, il, dn};
    endfunction

    task automatic push_one(input int i, input logic [5:0] o, input logic e, input logic r,
                            input logic [3:0] s, input logic last);
        exp_t x;
        x.op = o; x.en = e; x.rst = r; x.st = s;
        x.vec = exp_vec(s, last, e, (s == 4'd1) && illegal_opc(o, i));
        q.push_back(x);
    endtask

    // Queue n states (nibble 0 first); memory states occupy MEM_LAT cycles each.
    task automatic push_path(input int i, input logic [5:0] o, input int n, input logic [31:0] path);
        for (int k = 0; k < n; k++) begin
            logic [3:0] s;
            int cnt;
            s = path[4*k +: 4];
            cnt = (s == 4'd0 || s == 4'd3 || s == 4'd5) ? lat_of(i) : 1;
            for (int j = 0; j < cnt; j++) push_one(i, o, 1'b1, 1'b0, s, j == cnt - 1);
        end
    endtask

    task automatic step(input int i, output exp_t x, output logic [3:0] os, output logic [16:0] ov);
        x = q.pop_front();
        op[i] = x.op; en[i] = x.en; rst[i] = x.rst;
        @(negedge clk);
        os = st[i]; ov = vec[i];
        @(posedge clk); #1;
    endtask

    task automatic do_reset(input int i);
        rst[i] = 1'b1; en[i] = 1'b1;
        @(posedge clk); #1;
        rst[i] = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if (st[0] !== 4'd0 || vec[0] !== exp_vec(4'd0, 1'b1, 1'b1, 1'b0)) begin
            errors++;
            $display("FAIL reset_lat1 got st=%0d vec=%h exp st=0 vec=%h", st[0], vec[0], exp_vec(4'd0, 1'b1, 1'b1, 1'b0));
        end
        checks++;
        if (st[1] !== 4'd0 || vec[1] !== exp_vec(4'd0, 1'b0, 1'b1, 1'b0)) begin
            errors++;
            $display("FAIL reset_lat3 got st=%0d vec=%h exp st=0 vec=%h", st[1], vec[1], exp_vec(4'd0, 1'b0, 1'b1, 1'b0));
        end
        @(posedge clk); #1;
        en[0] = 1'b0;
        @(negedge clk);
        checks++;
        if (vec[0] !== exp_vec(4'd0, 1'b1, 1'b0, 1'b0)) begin
            errors++;
            $display("FAIL reset_en0 got vec=%h exp vec=%h", vec[0], exp_vec(4'd0, 1'b1, 1'b0, 1'b0));
        end
        @(posedge clk); #1;
        en[0] = 1'b1;
    endtask

    task automatic test_lw();
        exp_t x; logic [3:0] os; logic [16:0] ov; int c;
        do_reset(0);
        push_path(0, LW, 6, 32'h00043210);
        c = 0;
        while (q.size() > 0) begin
            step(0, x, os, ov); c++;
            checks++;
            if (os !== x.st) begin errors++; $display("FAIL lw_state cyc %0d got %0d exp %0d", c, os, x.st); end
            checks++;
            if (ov !== x.vec) begin errors++; $display("FAIL lw_ctrl cyc %0d got %h exp %h", c, ov, x.vec); end
        end
    endtask

    task automatic test_back_to_back();
        exp_t x; logic [3:0] os; logic [16:0] ov; int c;
        do_reset(0);
        push_path(0, RT, 4, 32'h7610);
        push_path(0, ADDI, 4, 32'hBA10);
        push_path(0, BEQ, 3, 32'h810);
        push_path(0, BGTZ, 3, 32'h910);
        push_path(0, JMP, 3, 32'hC10);
        push_path(0, RT, 1, 32'h0);
        c = 0;
        while (q.size() > 0) begin
            step(0, x, os, ov); c++;
            checks++;
            if (os !== x.st) begin errors++; $display("FAIL b2b_state cyc %0d got %0d exp %0d", c, os, x.st); end
            checks++;
            if (ov !== x.vec) begin errors++; $display("FAIL b2b_ctrl cyc %0d got %h exp %h", c, ov, x.vec); end
        end
    endtask

    task automatic test_sw_lat3();
        exp_t x; logic [3:0] os; logic [16:0] ov; int c;
        do_reset(1);
        push_path(1, SW, 5, 32'h05210);
        c = 0;
        while (q.size() > 0) begin
            step(1, x, os, ov); c++;
            checks++;
            if (os !== x.st) begin errors++; $display("FAIL sw3_state cyc %0d got %0d exp %0d", c, os, x.st); end
            checks++;
            if (ov !== x.vec) begin errors++; $display("FAIL sw3_ctrl cyc %0d got %h exp %h", c, ov, x.vec); end
        end
    endtask

    task automatic test_illegal();
        exp_t x; logic [3:0] os; logic [16:0] ov; int c;
        do_reset(0);
        push_path(0, BAD, 3, 32'h010);
        c = 0;
        while (q.size() > 0) begin
            step(0, x, os, ov); c++;
            checks++;
            if (os !== x.st) begin errors++; $display("FAIL ill_state cyc %0d got %0d exp %0d", c, os, x.st); end
            checks++;
            if (ov !== x.vec) begin errors++; $display("FAIL ill_ctrl cyc %0d got %h exp %h", c, ov, x.vec); end
        end
        do_reset(1);
        push_path(1, BGTZ, 3, 32'h010);
        c = 0;
        while (q.size() > 0) begin
            step(1, x, os, ov); c++;
            checks++;
            if (os !== x.st) begin errors++; $display("FAIL nobgtz_state cyc %0d got %0d exp %0d", c, os, x.st); end
            checks++;
            if (ov !== x.vec) begin errors++; $display("FAIL nobgtz_ctrl cyc %0d got %h exp %h", c, ov, x.vec); end
        end
    endtask

    task automatic test_stall();
        exp_t x; logic [3:0] os; logic [16:0] ov; int c;
        do_reset(2);
        push_path(2, LW, 3, 32'h210);
        push_one(2, LW, 1'b1, 1'b0, 4'd3, 1'b0);
        for (int k = 0; k < 4; k++) push_one(2, LW, 1'b0, 1'b0, 4'd3, 1'b1);
        push_one(2, LW, 1'b1, 1'b0, 4'd3, 1'b1);
        push_one(2, LW, 1'b1, 1'b0, 4'd4, 1'b1);
        push_one(2, LW, 1'b1, 1'b0, 4'd0, 1'b0);
        c = 0;
        while (q.size() > 0) begin
            step(2, x, os, ov); c++;
            checks++;
            if (os !== x.st) begin errors++; $display("FAIL stall_state cyc %0d got %0d exp %0d", c, os, x.st); end
            checks++;
            if (ov !== x.vec) begin errors++; $display("FAIL stall_ctrl cyc %0d got %h exp %h", c, ov, x.vec); end
        end
    endtask

    task automatic test_reset_memwr();
        exp_t x; logic [3:0] os; logic [16:0] ov; int c;
        do_reset(1);
        push_path(1, SW, 3, 32'h210);
        push_one(1, SW, 1'b1, 1'b0, 4'd5, 1'b0);
        push_one(1, SW, 1'b1, 1'b1, 4'd5, 1'b0);
        push_path(1, SW, 2, 32'h10);
        c = 0;
        while (q.size() > 0) begin
            step(1, x, os, ov); c++;
            checks++;
            if (os !== x.st) begin errors++; $display("FAIL rstwr_state cyc %0d got %0d exp %0d", c, os, x.st); end
            checks++;
            if (ov !== x.vec) begin errors++; $display("FAIL rstwr_ctrl cyc %0d got %h exp %h", c, ov, x.vec); end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < 3; i++) begin
            rst[i] = 1'b1; en[i] = 1'b1; op[i] = 6'd0;
        end
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_lw();
        test_back_to_back();
        test_sw_lat3();
        test_illegal();
        test_stall();
        test_reset_memwr();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
